// File: rtl/core_mem_pkg.sv
// Shared types and helpers for the core memory responder.
// Optional feature macro: CORE_MEM_ERR_EN (out-of-range error responses).
package core_mem_pkg;

  localparam int CM_ADDR_W = 32;
  localparam int CM_DATA_W = 32;
  localparam int CM_BE_W   = CM_DATA_W / 8;
  // addr[1:0] select a byte inside a word and never reach the array index
  localparam int IDX_LSB   = 2;

  // One response slot; the rdata width follows CM_DATA_W, which therefore
  // also fixes the data width of every responder built on this package.
  typedef struct packed {
    logic                 valid;
    logic [CM_DATA_W-1:0] rdata;
    logic                 err;
  } core_mem_rsp_t;

  // Number of word-index bits for a power-of-two array depth
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  // Merge wdata into old_word, one byte per set byte-enable bit
  function automatic logic [CM_DATA_W-1:0] apply_be(
    input logic [CM_DATA_W-1:0] old_word,
    input logic [CM_DATA_W-1:0] wdata,
    input logic [CM_BE_W-1:0]   be
  );
    logic [CM_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < CM_BE_W; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/core_mem_resp_if.sv
// req/gnt/rvalid core data/instruction port bundle.
// Optional feature macro: CORE_MEM_ERR_EN adds the err response signal.
interface core_mem_resp_if #(
  parameter int ADDR_W = core_mem_pkg::CM_ADDR_W,
  parameter int DATA_W = core_mem_pkg::CM_DATA_W,
  parameter int BE_W   = DATA_W / 8
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
`ifdef CORE_MEM_ERR_EN
  logic              err;
`endif

  modport master (
    output req, addr, we, be, wdata,
`ifdef CORE_MEM_ERR_EN
    input  err,
`endif
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
`ifdef CORE_MEM_ERR_EN
    output err,
`endif
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/core_mem_rsp_pipe.sv
// Fixed-latency response shift register; every stage clears asynchronously
// so responses in flight at reset are dropped.
module core_mem_rsp_pipe
  import core_mem_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  core_mem_rsp_t rsp_in,
  output core_mem_rsp_t rsp_out
);

  core_mem_rsp_t stage_reg [LAT];

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      // Stage gi takes the new response (gi==0) or the previous stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_reg[gi] <= '0;
        end else if (gi == 0) begin
          stage_reg[gi] <= rsp_in;
        end else begin
          stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign rsp_out = stage_reg[LAT-1];

endmodule

// File: rtl/core_mem_resp.sv
// Memory-side responder: grants after GNT_WAIT wait states, byte-enabled
// writes into a word array, in-order responses RVALID_LAT cycles after grant.
// Optional feature macro: CORE_MEM_ERR_EN (out-of-range accesses answer err=1).
module core_mem_resp
  import core_mem_pkg::*;
#(
  parameter int ADDR_W     = CM_ADDR_W,
  parameter int DATA_W     = CM_DATA_W,
  parameter int BE_W       = DATA_W / 8,
  parameter int DEPTH      = 1024,
  parameter int GNT_WAIT   = 0,
  parameter int RVALID_LAT = 1,
  parameter int MAX_OUTST  = 2
) (
  input logic            clk,
  input logic            rst,
  core_mem_resp_if.slave bus
);

  localparam int IDX_W   = idx_width(DEPTH);
  localparam int WAIT_W  = $clog2(GNT_WAIT + 2);
  localparam int OUTST_W = $clog2(MAX_OUTST + 2);

  // Zero at elaboration; reset deliberately leaves contents alone
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic [OUTST_W-1:0] outst_reg;
  logic [IDX_W-1:0]   idx;
  logic               in_range;
  logic               gnt;
  logic               hs;
  logic               unused_addr;
  core_mem_rsp_t      rsp_in;
  core_mem_rsp_t      rsp_out;

  assign idx = bus.addr[IDX_W+IDX_LSB-1:IDX_LSB];

`ifdef CORE_MEM_ERR_EN
  assign in_range    = (bus.addr[ADDR_W-1:IDX_W+IDX_LSB] == '0);
  assign unused_addr = ^bus.addr[IDX_LSB-1:0];
`else
  // Upper address bits alias onto the array
  assign in_range    = 1'b1;
  assign unused_addr = ^{bus.addr[ADDR_W-1:IDX_W+IDX_LSB], bus.addr[IDX_LSB-1:0]};
`endif

  // A response leaving the pipe this cycle frees a slot for a new grant;
  // reset blocks grants so no write can land on the reset edge.
  assign gnt = !rst && bus.req
             && (wait_cnt_reg == WAIT_W'(GNT_WAIT))
             && ((outst_reg < OUTST_W'(MAX_OUTST)) || rsp_out.valid);
  assign hs  = bus.req && gnt;

  // Count wait states while req is held without a grant, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else if (!bus.req || hs) begin
      wait_cnt_reg <= '0;
    end else if (wait_cnt_reg != WAIT_W'(GNT_WAIT)) begin
      wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
    end
  end

  // Track granted transactions whose response has not yet been issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_reg <= '0;
    end else if (hs && !rsp_out.valid) begin
      outst_reg <= outst_reg + OUTST_W'(1);
    end else if (!hs && rsp_out.valid) begin
      outst_reg <= outst_reg - OUTST_W'(1);
    end
  end

  // Byte-enabled array write on a write handshake
  always_ff @(posedge clk) begin
    if (hs && bus.we && in_range) begin
      mem[idx] <= apply_be(mem[idx], bus.wdata, bus.be);
    end
  end

  // Build the response at the handshake; reads see all earlier writes
  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = hs;
    rsp_in.err   = hs && !in_range;
    if (hs && !bus.we && in_range) begin
      rsp_in.rdata = mem[idx];
    end
  end

  core_mem_rsp_pipe #(
    .LAT (RVALID_LAT)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .rsp_in  (rsp_in),
    .rsp_out (rsp_out)
  );

  assign bus.gnt    = gnt;
  assign bus.rvalid = rsp_out.valid;
  assign bus.rdata  = rsp_out.rdata;
`ifdef CORE_MEM_ERR_EN
  assign bus.err    = rsp_out.err;
`else
  logic unused_err;
  assign unused_err = rsp_out.err;
`endif

endmodule

// File: tb/tb_core_mem_resp.sv
// Bench for core_mem_resp: three differently parameterised responders share
// one stimulus stream; each is checked every cycle against its own
// transaction-level model (due-time table of pending responses plus a
// sparse word memory). Build with CORE_MEM_ERR_EN to cover error responses.
module tb_core_mem_resp;

  localparam int NDUT = 3;
  localparam int DP [NDUT] = '{1024, 16, 16};
  localparam int LG [NDUT] = '{10, 4, 4};
  localparam int GW [NDUT] = '{0, 3, 0};
  localparam int LT [NDUT] = '{1, 2, 4};
  localparam int MO [NDUT] = '{2, 2, 2};

  logic        clk = 1'b0;
  logic        rst_d = 1'b1;
  logic        req_d = 1'b0;
  logic [31:0] addr_d = '0;
  logic        we_d = 1'b0;
  logic [3:0]  be_d = '0;
  logic [31:0] wdata_d = '0;

  logic        gnt_o [NDUT];
  logic        rv_o  [NDUT];
  logic [31:0] rd_o  [NDUT];
  logic        err_o [NDUT];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: pending responses keyed by (dut, due cycle) -> {err, rdata}
  logic [32:0] pend [int];
  logic [31:0] mmem [int];
  int          outst  [NDUT];
  int          waited [NDUT];

  always #5 clk = ~clk;

  core_mem_resp_if ifa ();
  core_mem_resp_if ifb ();
  core_mem_resp_if ifc ();

  assign ifa.req = req_d;  assign ifa.addr = addr_d;  assign ifa.we = we_d;
  assign ifa.be  = be_d;   assign ifa.wdata = wdata_d;
  assign ifb.req = req_d;  assign ifb.addr = addr_d;  assign ifb.we = we_d;
  assign ifb.be  = be_d;   assign ifb.wdata = wdata_d;
  assign ifc.req = req_d;  assign ifc.addr = addr_d;  assign ifc.we = we_d;
  assign ifc.be  = be_d;   assign ifc.wdata = wdata_d;

  assign gnt_o[0] = ifa.gnt;  assign rv_o[0] = ifa.rvalid;  assign rd_o[0] = ifa.rdata;
  assign gnt_o[1] = ifb.gnt;  assign rv_o[1] = ifb.rvalid;  assign rd_o[1] = ifb.rdata;
  assign gnt_o[2] = ifc.gnt;  assign rv_o[2] = ifc.rvalid;  assign rd_o[2] = ifc.rdata;
`ifdef CORE_MEM_ERR_EN
  assign err_o[0] = ifa.err;  assign err_o[1] = ifb.err;  assign err_o[2] = ifc.err;
`else
  assign err_o[0] = 1'b0;     assign err_o[1] = 1'b0;     assign err_o[2] = 1'b0;
`endif

  core_mem_resp #(.DEPTH(1024), .GNT_WAIT(0), .RVALID_LAT(1), .MAX_OUTST(2))
    dut_a (.clk(clk), .rst(rst_d), .bus(ifa));
  core_mem_resp #(.DEPTH(16), .GNT_WAIT(3), .RVALID_LAT(2), .MAX_OUTST(2))
    dut_b (.clk(clk), .rst(rst_d), .bus(ifb));
  core_mem_resp #(.DEPTH(16), .GNT_WAIT(0), .RVALID_LAT(4), .MAX_OUTST(2))
    dut_c (.clk(clk), .rst(rst_d), .bus(ifc));

  function automatic int pkey(input int k, input int c);
    return k * 1000000 + c;
  endfunction

  function automatic logic [31:0] mget(input int key);
    return mmem.exists(key) ? mmem[key] : 32'h0;
  endfunction

  task automatic clear_model();
    pend.delete();
    for (int k = 0; k < NDUT; k++) begin
      outst[k]  = 0;
      waited[k] = 0;
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check every DUT
  // against its model, advance the models, then move to the next falling edge.
  task automatic step(input logic r, input logic [31:0] a, input logic w,
                      input logic [3:0] b, input logic [31:0] d);
    logic        exp_rv, exp_gnt, exp_err, inr;
    logic [31:0] exp_rd, word;
    int          idx, mkey;
    req_d = r; addr_d = a; we_d = w; be_d = b; wdata_d = d;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      exp_rv  = pend.exists(pkey(k, cyc));
      exp_rd  = exp_rv ? pend[pkey(k, cyc)][31:0] : 32'h0;
      exp_err = exp_rv ? pend[pkey(k, cyc)][32] : 1'b0;
      exp_gnt = !rst_d && r && (waited[k] >= GW[k]) && (outst[k] < MO[k] || exp_rv);

      checks++;
      assert (gnt_o[k] === exp_gnt) else begin
        errors++;
        $error("FAIL gnt dut%0d cyc%0d got %b exp %b", k, cyc, gnt_o[k], exp_gnt);
      end
      checks++;
      assert (rv_o[k] === exp_rv) else begin
        errors++;
        $error("FAIL rvalid dut%0d cyc%0d got %b exp %b", k, cyc, rv_o[k], exp_rv);
      end
      checks++;
      assert (rd_o[k] === exp_rd) else begin
        errors++;
        $error("FAIL rdata dut%0d cyc%0d got %h exp %h", k, cyc, rd_o[k], exp_rd);
      end
`ifdef CORE_MEM_ERR_EN
      checks++;
      assert (err_o[k] === exp_err) else begin
        errors++;
        $error("FAIL err dut%0d cyc%0d got %b exp %b", k, cyc, err_o[k], exp_err);
      end
`endif

      if (!rst_d) begin
        if (exp_rv) begin
          pend.delete(pkey(k, cyc));
          outst[k]--;
        end
        if (exp_gnt) begin
          idx  = int'((a >> 2) & (DP[k] - 1));
          mkey = k * 100000 + idx;
`ifdef CORE_MEM_ERR_EN
          inr = ((a >> (LG[k] + 2)) == 0);
`else
          inr = 1'b1;
`endif
          pend[pkey(k, cyc + LT[k])] = {!inr, (!w && inr) ? mget(mkey) : 32'h0};
          outst[k]++;
          if (w && inr) begin
            word = mget(mkey);
            for (int j = 0; j < 4; j++) begin
              if (b[j]) word[8*j +: 8] = d[8*j +: 8];
            end
            mmem[mkey] = word;
          end
          waited[k] = 0;
        end else if (r) begin
          waited[k] = (waited[k] < GW[k]) ? waited[k] + 1 : GW[k];
        end else begin
          waited[k] = 0;
        end
      end
    end
    $display("cyc %0d rst=%b req=%b we=%b addr=%h be=%h wdata=%h gnt=%b%b%b rv=%b%b%b",
             cyc, rst_d, r, w, a, b, d, gnt_o[0], gnt_o[1], gnt_o[2],
             rv_o[0], rv_o[1], rv_o[2]);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  // Reset for n cycles while the master keeps issuing random requests
  task automatic reset_for(input int n);
    rst_d = 1'b1;
    clear_model();
    for (int i = 0; i < n; i++) begin
      step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, 1'($urandom_range(0, 1)),
           4'hF, $urandom);
    end
    rst_d = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    clear_model();
    @(negedge clk);

    // Reset state with requests pending: no grants, no responses
    reset_for(3);

    // Full-word write then read of 0x10
    step(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
    step(1'b1, 32'h10, 1'b0, 4'hF, 32'h0);
    checks++;
    assert (rv_o[0] === 1'b1 && rd_o[0] === 32'hDEADBEEF) else begin
      errors++;
      $error("FAIL t1_read got rv=%b rd=%h exp rv=1 rd=deadbeef", rv_o[0], rd_o[0]);
    end
    idle(6);

    // Partial write over zero memory, then read back
    step(1'b1, 32'h20, 1'b1, 4'b0101, 32'h11223344);
    step(1'b1, 32'h20, 1'b0, 4'hF, 32'h0);
    checks++;
    assert (rv_o[0] === 1'b1 && rd_o[0] === 32'h00220044) else begin
      errors++;
      $error("FAIL t2_partial got rv=%b rd=%h exp rv=1 rd=00220044", rv_o[0], rd_o[0]);
    end
    idle(6);

    // Single read held for several cycles: wait states on dut_b
    for (int i = 0; i < 5; i++) step(1'b1, 32'h10, 1'b0, 4'hF, 32'h0);
    idle(6);

    // Back-to-back reads held: outstanding limit stalls dut_c
    for (int i = 0; i < 10; i++) step(1'b1, 32'h20, 1'b0, 4'hF, 32'h0);
    idle(6);

    // Reset one cycle after a read grant drops the in-flight response
    step(1'b1, 32'h10, 1'b0, 4'hF, 32'h0);
    step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    reset_for(2);
    idle(5);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h10, 1'b0, 4'hF, 32'h0);
    idle(6);

    // Address above the array range: error response or alias
    step(1'b1, 32'h0000_1000, 1'b1, 4'hF, 32'hCAFEF00D);
`ifdef CORE_MEM_ERR_EN
    checks++;
    assert (rv_o[0] === 1'b1 && err_o[0] === 1'b1 && rd_o[0] === 32'h0) else begin
      errors++;
      $error("FAIL t6_oor got rv=%b err=%b rd=%h exp rv=1 err=1 rd=0",
             rv_o[0], err_o[0], rd_o[0]);
    end
`endif
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
    idle(6);

    // Randomised traffic with occasional high address bits
    for (int i = 0; i < 800; i++) begin
      ra = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ra = ra | 32'h0000_1000;
      if ($urandom_range(0, 9) == 0) ra = ra | 32'h0000_0100;
      step(($urandom_range(0, 9) < 7), ra, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), $urandom);
      if (i == 400) reset_for(2);
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
